dccm_port_arbiter: RTL
======================

Name: dccm_port_arbiter

Overview:
Shares the single DCCM read port and single DCCM write port between the LSU and a secondary DMA/debug requester.
- LSU always has priority and is never stalled by this block.
- DMA requests are granted only in free port slots.
- Read responses are steered back to their owner using a latency-matched owner pipe.
- A starvation counter requests a front-end bubble when the DMA has been locked out too long.
- Sits between the LSU and the DCCM macro.

Parameters:
XLEN, 32, data/address width
READ_LAT, 1, DCCM cycles from rvalid_in to rvalid_out (1..4)
RSP_DEPTH, 2, DMA read-response FIFO entries (power of 2, >=2)
STARVE_LIMIT, 16, consecutive blocked DMA cycles before a hold is requested (>=1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
lsu_dccm_raddr  in  XLEN  LSU read word address
lsu_dccm_rvalid_in  in  1  LSU read request
lsu_dccm_rdata  out  XLEN  read data to LSU
lsu_dccm_rvalid_out  out  1  LSU read data valid
lsu_dccm_waddr  in  XLEN  LSU write address
lsu_dccm_wen  in  1  LSU write enable
lsu_dccm_wdata  in  XLEN  LSU write data
lsu_busy  in  1  LSU has DC1/DC2 ops in flight
lsu_hold_req  out  1  request to IDU to stop issuing LSU ops
dma_req_valid  in  1  DMA request valid
dma_req_ready  out  1  DMA request accepted this cycle
dma_req_write  in  1  1 = write, 0 = read
dma_req_addr  in  XLEN  word address (bits [1:0] ignored)
dma_req_wdata  in  XLEN  write data (full word)
dma_rsp_valid  out  1  DMA read data valid
dma_rsp_ready  in  1  DMA consumes response
dma_rsp_rdata  out  XLEN  DMA read data
dccm_raddr  out  XLEN  to DCCM read address
dccm_rvalid_in  out  1  to DCCM read request
dccm_rdata  in  XLEN  from DCCM read data
dccm_rvalid_out  in  1  from DCCM read data valid
dccm_waddr  out  XLEN  to DCCM write address
dccm_wen  out  1  to DCCM write enable
dccm_wdata  out  XLEN  to DCCM write data

Behaviour:
- Reset (async, active-high):
  - owner pipe, FIFO, starvation counter and FSM clear.
  - All registered outputs go to 0.
  - dma_req_ready is forced 0 while rst=1.
  - DCCM responses arriving after reset are dropped.
- Read port:
  - lsu_dccm_rvalid_in=1 → LSU address and valid pass through combinationally (0 cycles).
  - Otherwise a DMA read is granted if dma_req_valid & ~dma_req_write & credit.
  - credit = fifo_count + dma_inflight < RSP_DEPTH.
  - Granted DMA address is {dma_req_addr[XLEN-1:2],2'b00}.
- Write port:
  - lsu_dccm_wen=1 → LSU passes through.
  - Otherwise a DMA write is granted if dma_req_valid & dma_req_write.
- dma_req_ready = grant for the requested type. It is combinational and independent of port activity of the other type.
- Owner pipe: READ_LAT-deep shift register of {valid, owner}, pushed on each dccm_rvalid_in.
  - On dccm_rvalid_out with owner=LSU → lsu_dccm_rvalid_out=1.
  - On dccm_rvalid_out with owner=DMA → push dccm_rdata into the FIFO.
  - lsu_dccm_rdata = dccm_rdata always.
  - dccm_rvalid_out with no valid owner entry is ignored.
- Response FIFO: dma_rsp_valid = ~empty; pop on valid & ready. Simultaneous push/pop at full is legal. Overflow is impossible by the credit rule.
- Starvation FSM:
  - NORMAL: counter increments each cycle dma_req_valid & ~dma_req_ready; clears on any DMA handshake or when valid drops. counter == STARVE_LIMIT-1 while still blocked → HOLD.
  - HOLD: lsu_hold_req=1 (registered); LSU traffic still has priority. DMA handshake → NORMAL, counter=0, hold deasserts next cycle.
  - HOLD with dma_req_valid dropped → NORMAL.
- No address hazard check between simultaneous LSU and DMA accesses to the same word; DCCM port semantics apply.

Optional Feature:
DCCM_ARB_PERF_EN
- Defined: adds outputs perf_dma_grants[31:0] (DMA handshakes) and perf_hold_events[31:0] (NORMAL→HOLD transitions).
  - Both are saturating counters and are cleared by rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. LSU read 0x100, no DMA → dccm_raddr=0x100 same cycle; lsu_dccm_rvalid_out=1 after READ_LAT; dma_rsp_valid stays 0.
2. DMA read 0x204 with the LSU idle → ready=1, dccm_raddr=0x204; DCCM data 0xDEADBEEF returned after READ_LAT → dma_rsp_rdata=0xDEADBEEF.
3. LSU write 0x40 and DMA write 0x80 in the same cycle → dccm_waddr=0x40, dma_req_ready=0; next cycle with the LSU idle → dccm_waddr=0x80, wdata passed through.
4. dma_rsp_ready=0 with 3 DMA reads issued back-to-back (RSP_DEPTH=2) → the 3rd is not accepted until a pop. No data is lost or reordered.
5. LSU reads every cycle, DMA read pending, STARVE_LIMIT=16 → lsu_hold_req=1 after 16 blocked cycles. Once the LSU drops rvalid_in the DMA is granted and hold clears the next cycle.
6. Assert rst with 1 DMA read in flight → FIFO empty, dma_rsp_valid=0 and the stale dccm_rvalid_out is ignored.

Source files
------------

// File: rtl/dccm_port_arbiter_if.sv
// Bundles the LSU, DMA/debug and DCCM-macro signals seen by dccm_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dccm_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lsu_dccm_raddr;
  logic            lsu_dccm_rvalid_in;
  logic [XLEN-1:0] lsu_dccm_rdata;
  logic            lsu_dccm_rvalid_out;
  logic [XLEN-1:0] lsu_dccm_waddr;
  logic            lsu_dccm_wen;
  logic [XLEN-1:0] lsu_dccm_wdata;
  logic            lsu_busy;
  logic            lsu_hold_req;
  logic            dma_req_valid;
  logic            dma_req_ready;
  logic            dma_req_write;
  logic [XLEN-1:0] dma_req_addr;
  logic [XLEN-1:0] dma_req_wdata;
  logic            dma_rsp_valid;
  logic            dma_rsp_ready;
  logic [XLEN-1:0] dma_rsp_rdata;
  logic [XLEN-1:0] dccm_raddr;
  logic            dccm_rvalid_in;
  logic [XLEN-1:0] dccm_rdata;
  logic            dccm_rvalid_out;
  logic [XLEN-1:0] dccm_waddr;
  logic            dccm_wen;
  logic [XLEN-1:0] dccm_wdata;

  modport slave (
    input  lsu_dccm_raddr, lsu_dccm_rvalid_in, lsu_dccm_waddr, lsu_dccm_wen,
           lsu_dccm_wdata, lsu_busy, dma_req_valid, dma_req_write, dma_req_addr,
           dma_req_wdata, dma_rsp_ready, dccm_rdata, dccm_rvalid_out,
    output lsu_dccm_rdata, lsu_dccm_rvalid_out, lsu_hold_req, dma_req_ready,
           dma_rsp_valid, dma_rsp_rdata, dccm_raddr, dccm_rvalid_in, dccm_waddr,
           dccm_wen, dccm_wdata
  );

  modport master (
    output lsu_dccm_raddr, lsu_dccm_rvalid_in, lsu_dccm_waddr, lsu_dccm_wen,
           lsu_dccm_wdata, lsu_busy, dma_req_valid, dma_req_write, dma_req_addr,
           dma_req_wdata, dma_rsp_ready, dccm_rdata, dccm_rvalid_out,
    input  lsu_dccm_rdata, lsu_dccm_rvalid_out, lsu_hold_req, dma_req_ready,
           dma_rsp_valid, dma_rsp_rdata, dccm_raddr, dccm_rvalid_in, dccm_waddr,
           dccm_wen, dccm_wdata
  );
endinterface

// File: rtl/dccm_port_arbiter.sv
// Shares the DCCM read/write ports between the LSU (absolute priority) and a DMA/debug requester.
// Optional DCCM_ARB_PERF_EN adds saturating DMA-grant and hold-event counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_NORMAL | counting consecutive cycles the DMA request is blocked
// ST_HOLD   | DMA starved; lsu_hold_req asserted until DMA handshake/drop
module dccm_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int READ_LAT     = 1,
  parameter int RSP_DEPTH    = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef DCCM_ARB_PERF_EN
  output logic [31:0]         perf_dma_grants,
  output logic [31:0]         perf_hold_events,
`endif
  dccm_port_arbiter_if.slave  bus
);

  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = CW + 3;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_NORMAL, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LAT-1:0] pipe_own_q, pipe_own_d;
  logic [XLEN-1:0]   mem_q [RSP_DEPTH];
  logic [XLEN-1:0]   mem_d [RSP_DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic [XLEN-1:0]   dma_addr_al;
  logic [SW-1:0]     inflight;
  logic              credit, rd_gnt, wr_gnt, handshake;
  logic              rsp_hit, fifo_push, fifo_pop, hold_event;
  logic              unused_bits;

  assign unused_bits = ^{bus.lsu_busy, bus.dma_req_addr[1:0]};

  assign dma_addr_al = {bus.dma_req_addr[XLEN-1:2], 2'b00};
  assign inflight    = SW'($countones(pipe_vld_q & pipe_own_q));
  assign credit      = (SW'(fifo_cnt_q) + inflight) < SW'(RSP_DEPTH);
  assign rd_gnt      = ~rst & ~bus.lsu_dccm_rvalid_in & bus.dma_req_valid &
                       ~bus.dma_req_write & credit;
  assign wr_gnt      = ~rst & ~bus.lsu_dccm_wen & bus.dma_req_valid & bus.dma_req_write;
  assign handshake   = rd_gnt | wr_gnt;

  assign bus.dma_req_ready  = bus.dma_req_write ? wr_gnt : rd_gnt;
  assign bus.dccm_raddr     = bus.lsu_dccm_rvalid_in ? bus.lsu_dccm_raddr : dma_addr_al;
  assign bus.dccm_rvalid_in = bus.lsu_dccm_rvalid_in | rd_gnt;
  assign bus.dccm_waddr     = bus.lsu_dccm_wen ? bus.lsu_dccm_waddr : dma_addr_al;
  assign bus.dccm_wdata     = bus.lsu_dccm_wen ? bus.lsu_dccm_wdata : bus.dma_req_wdata;
  assign bus.dccm_wen       = bus.lsu_dccm_wen | wr_gnt;

  // Oldest owner entry lines up with the DCCM data returning this cycle.
  assign rsp_hit                 = bus.dccm_rvalid_out & pipe_vld_q[READ_LAT-1];
  assign fifo_push               = rsp_hit & pipe_own_q[READ_LAT-1];
  assign bus.lsu_dccm_rvalid_out = rsp_hit & ~pipe_own_q[READ_LAT-1];
  assign bus.lsu_dccm_rdata      = bus.dccm_rdata;

  if (READ_LAT == 1) begin : g_pipe1
    always_comb begin
      pipe_vld_d = bus.dccm_rvalid_in;
      pipe_own_d = rd_gnt;
    end
  end else begin : g_pipen
    always_comb begin
      pipe_vld_d = {pipe_vld_q[READ_LAT-2:0], bus.dccm_rvalid_in};
      pipe_own_d = {pipe_own_q[READ_LAT-2:0], rd_gnt};
    end
  end

  assign bus.dma_rsp_valid = (fifo_cnt_q != '0);
  assign bus.dma_rsp_rdata = mem_q[rp_q];
  assign fifo_pop          = bus.dma_rsp_valid & bus.dma_rsp_ready;

  always_comb begin
    mem_d = mem_q;
    if (fifo_push) mem_d[wp_q] = bus.dccm_rdata;
    wp_d       = wp_q + PW'(fifo_push);
    rp_d       = rp_q + PW'(fifo_pop);
    fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    hold_event   = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (!bus.dma_req_valid || handshake) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q == SCW'(STARVE_LIMIT - 1)) begin
          state_d      = ST_HOLD;
          starve_cnt_d = '0;
          hold_event   = 1'b1;
        end else begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        starve_cnt_d = '0;
        if (!bus.dma_req_valid || handshake) state_d = ST_NORMAL;
      end
      default: begin
        state_d      = ST_NORMAL;
        starve_cnt_d = '0;
      end
    endcase
  end

  assign bus.lsu_hold_req = (state_q == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
      pipe_vld_q   <= '0;
      pipe_own_q   <= '0;
      mem_q        <= '{default: '0};
      wp_q         <= '0;
      rp_q         <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_own_q   <= pipe_own_d;
      mem_q        <= mem_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

`ifdef DCCM_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_holds_q, perf_holds_d;

  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_holds_d  = perf_holds_q;
    if (handshake && (perf_grants_q != '1)) perf_grants_d = perf_grants_q + 1'b1;
    if (hold_event && (perf_holds_q != '1)) perf_holds_d = perf_holds_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grants_q <= '0;
      perf_holds_q  <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_holds_q  <= perf_holds_d;
    end
  end

  assign perf_dma_grants  = perf_grants_q;
  assign perf_hold_events = perf_holds_q;
`else
  logic unused_hold_event;
  assign unused_hold_event = hold_event;
`endif

endmodule
